// File: rtl/servant_wb_arbiter.sv
// servant_wb_arbiter: shares one Wishbone slave port between two masters with
// round-robin or fixed-priority grant, one transaction per grant, and a bus watchdog.
module servant_wb_arbiter #(
   parameter int PRIO_M0 = 0,
   parameter int TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_m0_adr,
   input  logic [31:0] i_wb_m0_dat,
   input  logic [3:0]  i_wb_m0_sel,
   input  logic        i_wb_m0_we,
   input  logic        i_wb_m0_cyc,
   output logic [31:0] o_wb_m0_rdt,
   output logic        o_wb_m0_ack,
   input  logic [31:0] i_wb_m1_adr,
   input  logic [31:0] i_wb_m1_dat,
   input  logic [3:0]  i_wb_m1_sel,
   input  logic        i_wb_m1_we,
   input  logic        i_wb_m1_cyc,
   output logic [31:0] o_wb_m1_rdt,
   output logic        o_wb_m1_ack,
   output logic [31:0] o_wb_s_adr,
   output logic [31:0] o_wb_s_dat,
   output logic [3:0]  o_wb_s_sel,
   output logic        o_wb_s_we,
   output logic        o_wb_s_cyc,
   input  logic [31:0] i_wb_s_rdt,
   input  logic        i_wb_s_ack,
   output logic        o_timeout
);
   localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WLIM = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   localparam logic WD_EN = TIMEOUT != 0;
   localparam logic PRIO = PRIO_M0 != 0;
   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
   state_t state, state_n;
   logic grant, grant_n, last, last_n;
   logic [WW-1:0] wdog, wdog_n;
   logic g_cyc, busy, forced, done;
   assign g_cyc = grant ? i_wb_m1_cyc : i_wb_m0_cyc;
   // outputs are held quiet during reset so a dropped transaction never acks
   assign busy = !i_rst && state == BUSY && g_cyc;
   assign forced = busy && WD_EN && !i_wb_s_ack && wdog == WLIM;
   assign done = busy && (i_wb_s_ack || forced);
   assign o_wb_s_adr = grant ? i_wb_m1_adr : i_wb_m0_adr;
   assign o_wb_s_dat = grant ? i_wb_m1_dat : i_wb_m0_dat;
   assign o_wb_s_sel = grant ? i_wb_m1_sel : i_wb_m0_sel;
   assign o_wb_s_we = grant ? i_wb_m1_we : i_wb_m0_we;
   assign o_wb_s_cyc = busy && !forced;
   assign o_wb_m0_ack = done && !grant;
   assign o_wb_m1_ack = done && grant;
   assign o_wb_m0_rdt = forced ? '0 : i_wb_s_rdt;
   assign o_wb_m1_rdt = forced ? '0 : i_wb_s_rdt;
   assign o_timeout = forced;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         grant <= 1'b0;
         last <= 1'b1;
         wdog <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         last <= last_n;
         wdog <= wdog_n;
      end
   end
   always_comb begin
      state_n = state;
      grant_n = grant;
      last_n = last;
      wdog_n = wdog;
      case (state)
         IDLE: if (i_wb_m0_cyc || i_wb_m1_cyc) begin
            grant_n = (i_wb_m0_cyc && i_wb_m1_cyc) ? (PRIO ? 1'b0 : !last) : i_wb_m1_cyc;
            state_n = BUSY;
            wdog_n = '0;
         end
         BUSY: if (!g_cyc) begin
            last_n = grant;
            state_n = IDLE;
         end else if (done) begin
            last_n = grant;
            state_n = GAP;
         end else if (wdog != '1) begin
            wdog_n = wdog + WW'(1);
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_servant_wb_arbiter.sv
// tb_servant_wb_arbiter: round-robin and fixed-priority arbiters driven side by side by
// random masters/slaves; a transaction-level owner model feeds a scoreboard checked by a monitor.
module tb_servant_wb_arbiter;
   localparam int TMO = 8;
   logic clk = 0;
   logic rst = 1;
   always #5 clk = ~clk;
   logic [31:0] m_adr[2][2], m_dat[2][2], m_rdt[2][2];
   logic [3:0]  m_sel[2][2];
   logic        m_we[2][2], m_cyc[2][2], m_ack[2][2];
   logic [31:0] s_adr[2], s_dat[2], s_rdt[2];
   logic [3:0]  s_sel[2];
   logic        s_we[2], s_cyc[2], s_ack[2], tmo[2];
   for (genvar d = 0; d < 2; d++) begin : g_dut
      servant_wb_arbiter #(.PRIO_M0(d), .TIMEOUT(TMO)) dut (
         .i_clk(clk), .i_rst(rst),
         .i_wb_m0_adr(m_adr[d][0]), .i_wb_m0_dat(m_dat[d][0]), .i_wb_m0_sel(m_sel[d][0]),
         .i_wb_m0_we(m_we[d][0]), .i_wb_m0_cyc(m_cyc[d][0]), .o_wb_m0_rdt(m_rdt[d][0]),
         .o_wb_m0_ack(m_ack[d][0]),
         .i_wb_m1_adr(m_adr[d][1]), .i_wb_m1_dat(m_dat[d][1]), .i_wb_m1_sel(m_sel[d][1]),
         .i_wb_m1_we(m_we[d][1]), .i_wb_m1_cyc(m_cyc[d][1]), .o_wb_m1_rdt(m_rdt[d][1]),
         .o_wb_m1_ack(m_ack[d][1]),
         .o_wb_s_adr(s_adr[d]), .o_wb_s_dat(s_dat[d]), .o_wb_s_sel(s_sel[d]),
         .o_wb_s_we(s_we[d]), .o_wb_s_cyc(s_cyc[d]), .i_wb_s_rdt(s_rdt[d]),
         .i_wb_s_ack(s_ack[d]), .o_timeout(tmo[d])
      );
   end
   typedef struct {int k; int who; logic [31:0] rdt; bit tmo; int cyc;} ack_t;
   typedef struct {int k; bit own; bit cyc; bit tmo; logic [31:0] adr; logic [31:0] dat;
                   logic [3:0] sel; logic we;} bus_t;
   ack_t ack_q[$];
   bus_t bus_q[$];
   int total = 0, bad = 0, now = 0;
   int want[2][2], p_req[2][2], nack[2][2], ntmo[2];
   int p_abort = 0, dly_fix = 2;
   bit fix_adr = 0, use_rdt_fix = 0, rst_req = 1;
   logic [31:0] rdt_fix = 32'h1234_5678;
   bit seen_ack[2][2];
   int scnt[2], dly[2];
   int owner[2] = '{-1, -1}, last[2] = '{1, 1}, waited[2];
   bit cool[2];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h want=%h", name, now, act, exp_v);
      end
   endtask
   // Reference: who owns the slave port, a one-cycle cool-down after a completed
   // transaction, and arbitration among the requests present in a free cycle.
   task automatic model(input int k);
      bus_t e;
      e = '{k: k, own: 0, cyc: 0, tmo: 0, adr: 0, dat: 0, sel: 0, we: 0};
      if (rst) begin
         owner[k] = -1;
         cool[k] = 0;
         last[k] = 1;
      end else if (owner[k] >= 0) begin
         int o;
         o = owner[k];
         e.own = 1;
         e.adr = m_adr[k][o];
         e.dat = m_dat[k][o];
         e.sel = m_sel[k][o];
         e.we = m_we[k][o];
         if (!m_cyc[k][o]) begin
            last[k] = o;
            owner[k] = -1;
         end else if (s_ack[k] || waited[k] == TMO - 1) begin
            e.tmo = !s_ack[k];
            e.cyc = s_ack[k];
            ack_q.push_back('{k: k, who: o, rdt: s_ack[k] ? s_rdt[k] : 32'h0, tmo: !s_ack[k], cyc: now});
            last[k] = o;
            owner[k] = -1;
            cool[k] = 1;
         end else begin
            e.cyc = 1;
            waited[k]++;
         end
      end else if (cool[k]) begin
         cool[k] = 0;
      end else if (m_cyc[k][0] || m_cyc[k][1]) begin
         owner[k] = (m_cyc[k][0] && m_cyc[k][1]) ? (k == 1 ? 0 : 1 - last[k]) : (m_cyc[k][1] ? 1 : 0);
         waited[k] = 0;
      end
      bus_q.push_back(e);
   endtask
   task automatic step();
      @(posedge clk);
      now++;
      #1;
      rst = rst_req;
      for (int k = 0; k < 2; k++)
         for (int m = 0; m < 2; m++)
            if (m_cyc[k][m]) begin
               if (seen_ack[k][m] || $urandom_range(99) < p_abort) m_cyc[k][m] = 0;
            end else if (want[k][m] > 0 || $urandom_range(99) < p_req[k][m]) begin
               if (want[k][m] > 0) want[k][m]--;
               m_cyc[k][m] = 1;
               m_adr[k][m] = fix_adr ? 32'h4000_0000 : $urandom;
               m_dat[k][m] = $urandom;
               m_sel[k][m] = 4'($urandom);
               m_we[k][m] = fix_adr ? 1'b0 : 1'($urandom);
            end
      for (int k = 0; k < 2; k++) s_ack[k] = 0;
      #1;
      for (int k = 0; k < 2; k++)
         if (!(s_cyc[k] || tmo[k])) scnt[k] = 0;
         else begin
            if (scnt[k] == 0) dly[k] = dly_fix >= 0 ? dly_fix : $urandom_range(9);
            if (scnt[k] == dly[k]) begin
               s_ack[k] = 1;
               s_rdt[k] = use_rdt_fix ? rdt_fix : $urandom;
            end
            scnt[k]++;
         end
      #1;
      for (int k = 0; k < 2; k++) begin
         model(k);
         ntmo[k] += int'(tmo[k]);
         for (int m = 0; m < 2; m++) begin
            seen_ack[k][m] = m_ack[k][m];
            nack[k][m] += int'(m_ack[k][m]);
         end
      end
   endtask
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (bus_q.size() > 0) begin
            bus_t e;
            e = bus_q.pop_front();
            chk($sformatf("s_cyc[%0d]", k), 32'(s_cyc[k]), 32'(e.cyc));
            chk($sformatf("timeout[%0d]", k), 32'(tmo[k]), 32'(e.tmo));
            if (e.own) begin
               chk($sformatf("s_adr[%0d]", k), s_adr[k], e.adr);
               chk($sformatf("s_dat_sel_we[%0d]", k), {s_dat[k][26:0], s_sel[k], s_we[k]},
                   {e.dat[26:0], e.sel, e.we});
            end
         end
         for (int m = 0; m < 2; m++)
            if (m_ack[k][m]) begin
               if (ack_q.size() > 0 && ack_q[0].k == k && ack_q[0].cyc == now) begin
                  ack_t a;
                  a = ack_q.pop_front();
                  chk($sformatf("ack_who[%0d]", k), m, a.who);
                  chk($sformatf("ack_rdt[%0d]", k), m_rdt[k][m], a.rdt);
                  chk($sformatf("ack_tmo[%0d]", k), 32'(tmo[k]), 32'(a.tmo));
               end else chk($sformatf("spurious_ack[%0d].m%0d", k, m), 1, 0);
            end
      end
      while (ack_q.size() > 0 && ack_q[0].cyc <= now) begin
         chk($sformatf("missed_ack[%0d]", ack_q[0].k), 0, 1);
         void'(ack_q.pop_front());
      end
   end
   task automatic clear();
      for (int k = 0; k < 2; k++) begin
         ntmo[k] = 0;
         for (int m = 0; m < 2; m++) nack[k][m] = 0;
      end
   endtask
   initial begin
      for (int k = 0; k < 2; k++) begin
         s_ack[k] = 0;
         s_rdt[k] = 0;
         for (int m = 0; m < 2; m++) begin
            m_cyc[k][m] = 0;
            m_adr[k][m] = 0;
            m_dat[k][m] = 0;
            m_sel[k][m] = 0;
            m_we[k][m] = 0;
            want[k][m] = 0;
            p_req[k][m] = 0;
         end
      end
      clear();
      repeat (3) step();
      rst_req = 0;
      // single m0 read, slave acks one cycle after s_cyc
      fix_adr = 1;
      use_rdt_fix = 1;
      dly_fix = 1;
      for (int k = 0; k < 2; k++) want[k][0] = 1;
      repeat (8) step();
      for (int k = 0; k < 2; k++) begin
         chk("t1_m0_acks", nack[k][0], 1);
         chk("t1_m1_acks", nack[k][1], 0);
      end
      fix_adr = 0;
      use_rdt_fix = 0;
      // both masters held from reset
      rst_req = 1;
      step();
      rst_req = 0;
      clear();
      dly_fix = 2;
      for (int k = 0; k < 2; k++) begin
         want[k][0] = 3;
         want[k][1] = 3;
      end
      repeat (40) step();
      chk("t2_rr_m0_acks", nack[0][0], 3);
      chk("t2_rr_m1_acks", nack[0][1], 3);
      // fixed priority starves m1 while m0 keeps requesting
      clear();
      for (int k = 0; k < 2; k++) begin
         want[k][0] = 6;
         want[k][1] = 1;
      end
      repeat (20) step();
      chk("t3_fp_m1_starved", nack[1][1], 0);
      chk("t3_fp_m0_served", 32'(nack[1][0] >= 3), 1);
      repeat (30) step();
      chk("t3_fp_m0_acks", nack[1][0], 6);
      chk("t3_fp_m1_after", nack[1][1], 1);
      // silent slave -> watchdog ack, then a normal m1 transfer
      clear();
      dly_fix = 100;
      for (int k = 0; k < 2; k++) want[k][0] = 1;
      repeat (14) step();
      for (int k = 0; k < 2; k++) begin
         chk("t4_timeouts", ntmo[k], 1);
         chk("t4_m0_forced_ack", nack[k][0], 1);
      end
      dly_fix = 2;
      for (int k = 0; k < 2; k++) want[k][1] = 1;
      repeat (8) step();
      for (int k = 0; k < 2; k++) begin
         chk("t4_m1_ack", nack[k][1], 1);
         chk("t4_no_new_timeout", ntmo[k], 1);
      end
      // slave ack on the threshold cycle wins
      clear();
      dly_fix = TMO - 1;
      for (int k = 0; k < 2; k++) want[k][0] = 1;
      repeat (14) step();
      for (int k = 0; k < 2; k++) begin
         chk("t5_edge_ack", nack[k][0], 1);
         chk("t5_edge_no_timeout", ntmo[k], 0);
      end
      // reset while BUSY
      clear();
      dly_fix = 100;
      for (int k = 0; k < 2; k++) want[k][0] = 1;
      repeat (4) step();
      rst_req = 1;
      step();
      rst_req = 0;
      step();
      for (int k = 0; k < 2; k++) begin
         chk("t5_rst_no_ack", nack[k][0] + nack[k][1], 0);
         chk("t5_rst_s_cyc", 32'(s_cyc[k]), 0);
      end
      dly_fix = 2;
      repeat (10) step();
      // random traffic with occasional aborts and timeouts
      dly_fix = -1;
      p_abort = 3;
      for (int k = 0; k < 2; k++)
         for (int m = 0; m < 2; m++) p_req[k][m] = 30;
      repeat (3000) step();
      p_abort = 0;
      dly_fix = 2;
      for (int k = 0; k < 2; k++)
         for (int m = 0; m < 2; m++) p_req[k][m] = 0;
      repeat (40) step();
      @(posedge clk);
      #2;
      chk("ack_q_drained", ack_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
